// File: rtl/axis_chk_pkg.sv
// Shared definitions for the AXI-Stream packet checker: FSM states, ready-mode
// encodings and the backpressure LFSR polynomial.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } chk_state_t;

  localparam logic [1:0] BP_ALWAYS = 2'd0;
  localparam logic [1:0] BP_LFSR   = 2'd1;
  localparam logic [1:0] BP_ALT    = 2'd2;
  localparam logic [1:0] BP_NEVER  = 2'd3;

  // x^8+x^6+x^5+x^4+1, Fibonacci form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_bp_gen.sv
// Registered ready generator for stream sinks: always, LFSR-gated, alternating
// or never ready; 'hold' forces the next ready low.
module axis_bp_gen
  import axis_chk_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bp_mode,
  input  logic       hold,
  output logic       ready
);

  logic [7:0] lfsr;
  logic       ready_nxt;

  always_comb begin
    ready_nxt = 1'b0;
    if (!hold) begin
      case (bp_mode)
        BP_ALWAYS: ready_nxt = 1'b1;
        BP_LFSR:   ready_nxt = lfsr[0];
        BP_ALT:    ready_nxt = ~ready;
        BP_NEVER:  ready_nxt = 1'b0;
      endcase
    end
  end

  // LFSR free-runs every cycle regardless of mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      ready <= 1'b0;
    end else begin
      lfsr  <= lfsr_step(lfsr);
      ready <= ready_nxt;
    end
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet sink: checks an incrementing payload and the beat count
// against the length on tuser, reporting a per-packet verdict and counters.
module axis_pkt_checker
  import axis_chk_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    USER_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] FIRST_DATA = DATA_WIDTH'(1),
  parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_axis_data,
  input  logic [USER_WIDTH-1:0] i_axis_user,
  input  logic                  i_axis_valid,
  input  logic                  i_axis_last,
  output logic                  o_axis_ready,
  input  logic [1:0]            i_bp_mode,
  output logic                  o_pkt_done,
  output logic                  o_pkt_ok,
  output logic                  o_err_data,
  output logic                  o_err_len,
  input  logic                  i_clr,
  output logic [15:0]           o_pkt_cnt,
  output logic [15:0]           o_err_cnt
);

  chk_state_t            state, state_nxt;
  logic                  xfer, hold;
  logic                  data_bad, len_bad;
  logic                  pkt_data_err, pkt_len_err;
  logic [USER_WIDTH-1:0] len, beat_cnt, beat_inc;
  logic [DATA_WIDTH-1:0] expected;

  assign xfer     = i_axis_valid && o_axis_ready;
  assign beat_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
  // Ready is registered, so it must already be low during the REPORT cycle
  assign hold     = (state_nxt == ST_REPORT);

  axis_bp_gen #(.LFSR_SEED(LFSR_SEED)) u_bp_gen (
    .clk     (i_clk),
    .rst     (i_rst),
    .bp_mode (i_bp_mode),
    .hold    (hold),
    .ready   (o_axis_ready)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    data_bad   = 1'b0;
    len_bad    = 1'b0;
    o_pkt_done = 1'b0;
    o_pkt_ok   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          data_bad = (i_axis_data != FIRST_DATA);
          if (i_axis_last) begin
            len_bad   = (i_axis_user != USER_WIDTH'(1));
            state_nxt = ST_REPORT;
          end else begin
            state_nxt = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (xfer) begin
          data_bad = (i_axis_data != expected);
          len_bad  = (i_axis_user != len);
          if (i_axis_last) begin
            len_bad   = len_bad || (beat_inc != len);
            state_nxt = ST_REPORT;
          end
        end
      end
      ST_REPORT: begin
        o_pkt_done = 1'b1;
        o_pkt_ok   = !(pkt_data_err || pkt_len_err);
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Expected data always resyncs to the received beat so a dropped beat costs one mismatch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      len          <= '0;
      beat_cnt     <= '0;
      expected     <= FIRST_DATA;
      pkt_data_err <= 1'b0;
      pkt_len_err  <= 1'b0;
      o_err_data   <= 1'b0;
      o_err_len    <= 1'b0;
      o_pkt_cnt    <= '0;
      o_err_cnt    <= '0;
    end else begin
      if (xfer) begin
        expected <= i_axis_data + 1'b1;
        if (state == ST_IDLE) begin
          len          <= i_axis_user;
          beat_cnt     <= USER_WIDTH'(1);
          pkt_data_err <= data_bad;
          pkt_len_err  <= len_bad;
        end else begin
          beat_cnt     <= beat_inc;
          pkt_data_err <= pkt_data_err | data_bad;
          pkt_len_err  <= pkt_len_err | len_bad;
        end
      end
      if (state == ST_REPORT) expected <= FIRST_DATA;

      if (i_clr) begin
        o_err_data <= 1'b0;
        o_err_len  <= 1'b0;
        o_pkt_cnt  <= '0;
        o_err_cnt  <= '0;
      end else begin
        if (data_bad) o_err_data <= 1'b1;
        if (len_bad)  o_err_len  <= 1'b1;
        if (state == ST_REPORT) begin
          o_pkt_cnt <= o_pkt_cnt + 1'b1;
          if (!o_pkt_ok && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
